// File: rtl/data_mem_ctrl_pkg.sv
// Shared encodings for the data-memory load/store sequencer.
package data_mem_ctrl_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAPT,
        S_MERGE,
        S_WR,
        S_RESP
    } state_e;

    // Alignment/size legality only; range is checked by the caller.
    function automatic logic bad_align(input logic [1:0] size, input logic [1:0] lo);
        return (size == SIZE_X) || (size == SIZE_H && lo[0]) || (size == SIZE_W && lo != 2'b00);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane extract/extend for loads and lane merge for sub-word stores.
module mem_lane_align
    import data_mem_ctrl_pkg::*;
#(
    parameter int RAM_WIDTH = 32
) (
    input  logic [RAM_WIDTH-1:0] rdata_i,
    input  logic [1:0]           size_i,
    input  logic                 unsigned_i,
    input  logic [1:0]           lane_i,
    input  logic [RAM_WIDTH-1:0] wdata_i,
    output logic [RAM_WIDTH-1:0] load_o,
    output logic [RAM_WIDTH-1:0] merge_o
);

    localparam int SHW = $clog2(RAM_WIDTH);

    logic [1:0]           lane;
    logic [SHW-1:0]       sh;
    logic [RAM_WIDTH-1:0] shifted;
    logic [RAM_WIDTH-1:0] mask;

    always_comb begin
        lane    = (size_i == SIZE_H) ? {lane_i[1], 1'b0} : lane_i;
        sh      = SHW'({lane, 3'b000});
        shifted = rdata_i >> sh;
        load_o  = rdata_i;
        mask    = '1;
        case (size_i)
            SIZE_B: begin
                load_o = unsigned_i ? {{(RAM_WIDTH-BYTE_W){1'b0}}, shifted[BYTE_W-1:0]}
                                    : {{(RAM_WIDTH-BYTE_W){shifted[BYTE_W-1]}}, shifted[BYTE_W-1:0]};
                mask   = RAM_WIDTH'({BYTE_W{1'b1}}) << sh;
            end
            SIZE_H: begin
                load_o = unsigned_i ? {{(RAM_WIDTH-HALF_W){1'b0}}, shifted[HALF_W-1:0]}
                                    : {{(RAM_WIDTH-HALF_W){shifted[HALF_W-1]}}, shifted[HALF_W-1:0]};
                mask   = RAM_WIDTH'({HALF_W{1'b1}}) << sh;
            end
            default: ;
        endcase
        merge_o = (rdata_i & ~mask) | ((wdata_i << sh) & mask);
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store sequencer: single-beat word access, read-modify-write for sub-word stores.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int RAM_WIDTH     = 32,
    parameter int RAM_ADDR_BITS = 9
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    input  logic [31:0]              req_addr,
    input  logic [RAM_WIDTH-1:0]     req_wdata,
    output logic                     resp_valid,
    output logic [RAM_WIDTH-1:0]     resp_rdata,
    output logic                     resp_error,
    output logic                     ram_enable,
    output logic                     ram_write_enable,
    output logic [RAM_ADDR_BITS-1:0] ram_address,
    output logic [RAM_WIDTH-1:0]     ram_input_data,
    input  logic [RAM_WIDTH-1:0]     ram_output_data
);

    state_e                   state_q;
    logic                     write_q;
    logic [1:0]               size_q;
    logic                     uns_q;
    logic [1:0]               lane_q;
    logic [RAM_WIDTH-1:0]     wdata_q;
    logic [RAM_ADDR_BITS-1:0] ram_address_q;
    logic [RAM_WIDTH-1:0]     ram_input_data_q;
    logic [RAM_WIDTH-1:0]     resp_rdata_q;
    logic                     resp_error_q;

    logic                     req_err_d;
    logic [RAM_WIDTH-1:0]     load_data;
    logic [RAM_WIDTH-1:0]     merge_data;

    always_comb begin
        req_err_d = bad_align(req_size, req_addr[1:0]) || (|req_addr[31:RAM_ADDR_BITS+2]);
    end

    mem_lane_align #(.RAM_WIDTH(RAM_WIDTH)) u_align (
        .rdata_i    (ram_output_data),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .lane_i     (lane_q),
        .wdata_i    (wdata_q),
        .load_o     (load_data),
        .merge_o    (merge_data)
    );

    // Enables decode from the state register so reset drops them without waiting for a clock.
    assign req_ready        = (state_q == S_IDLE);
    assign resp_valid       = (state_q == S_RESP);
    assign ram_enable       = (state_q == S_RD) || (state_q == S_WR);
    assign ram_write_enable = (state_q == S_WR);
    assign ram_address      = ram_address_q;
    assign ram_input_data   = ram_input_data_q;
    assign resp_rdata       = resp_rdata_q;
    assign resp_error       = resp_error_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            write_q          <= 1'b0;
            size_q           <= SIZE_B;
            uns_q            <= 1'b0;
            lane_q           <= 2'b00;
            wdata_q          <= '0;
            ram_address_q    <= '0;
            ram_input_data_q <= '0;
            resp_rdata_q     <= '0;
            resp_error_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (req_valid) begin
                    write_q       <= req_write;
                    size_q        <= req_size;
                    uns_q         <= req_unsigned;
                    lane_q        <= req_addr[1:0];
                    wdata_q       <= req_wdata;
                    ram_address_q <= req_addr[RAM_ADDR_BITS+1:2];
                    resp_rdata_q  <= '0;
                    resp_error_q  <= req_err_d;
                    if (req_err_d) begin
                        state_q <= S_RESP;
                    end else if (req_write && req_size == SIZE_W) begin
                        ram_input_data_q <= req_wdata;
                        state_q          <= S_WR;
                    end else begin
                        state_q <= S_RD;
                    end
                end
                S_RD:    state_q <= write_q ? S_MERGE : S_CAPT;
                S_CAPT: begin
                    resp_rdata_q <= load_data;
                    state_q      <= S_RESP;
                end
                S_MERGE: begin
                    ram_input_data_q <= merge_data;
                    state_q          <= S_WR;
                end
                S_WR:    state_q <= S_RESP;
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a behavioural write-first synchronous RAM.
module tb_data_mem_ctrl;
    import data_mem_ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_error, ram_enable, ram_write_enable;
    logic [31:0] resp_rdata, ram_input_data, ram_output_data;
    logic [8:0]  ram_address;

    logic [31:0] mem [0:511];
    logic        pl_en = 1'b0;
    logic [8:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    int tests = 0, fails = 0;
    int r_lat, r_en, r_we;
    logic [31:0] r_data;
    logic        r_err;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_enable) begin
            if (ram_write_enable) begin
                mem[ram_address] <= ram_input_data;
                ram_output_data  <= ram_input_data;
            end else ram_output_data <= mem[ram_address];
        end
    end

    data_mem_ctrl #(.RAM_WIDTH(32), .RAM_ADDR_BITS(9)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .ram_enable(ram_enable),
        .ram_write_enable(ram_write_enable), .ram_address(ram_address),
        .ram_input_data(ram_input_data), .ram_output_data(ram_output_data)
    );

    task automatic preload(input logic [8:0] a, input logic [31:0] d);
        @(negedge clock);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clock); #1 pl_en = 1'b0;
    endtask

    // Issues one request and records latency (negedges after accept), enable counts and response.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
        @(posedge clock); #1 req_valid = 1'b0;
        r_lat = 0; r_en = 0; r_we = 0; r_data = 'x; r_err = 1'bx;
        for (int c = 1; c <= 20 && r_lat == 0; c++) begin
            @(negedge clock);
            if (ram_enable) r_en++;
            if (ram_write_enable) r_we++;
            if (resp_valid) begin r_lat = c; r_data = resp_rdata; r_err = resp_error; end
        end
    endtask

    task automatic test_reset();
        #1;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        tests++; if (resp_error !== 1'b0) begin fails++; $display("FAIL reset_resp_error: got %b want 0", resp_error); end
        tests++; if (resp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
        tests++; if ({ram_enable, ram_write_enable} !== 2'b00) begin fails++; $display("FAIL reset_enables: got %b want 00", {ram_enable, ram_write_enable}); end
        tests++; if (ram_address !== 9'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", ram_address); end
        tests++; if (ram_input_data !== 32'h0) begin fails++; $display("FAIL reset_wdata: got %h want 0", ram_input_data); end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_loads();
        logic [1:0]  sz [5] = '{SIZE_W, SIZE_B, SIZE_B, SIZE_H, SIZE_H};
        logic        un [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ad [5] = '{32'h0, 32'h3, 32'h3, 32'h2, 32'h0};
        logic [31:0] ex [5] = '{32'h87654321, 32'hFFFFFF87, 32'h00000087, 32'hFFFF8765, 32'h00004321};
        preload(9'd0, 32'h87654321);
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, sz[i], un[i], ad[i], 32'h0);
            tests++; if (r_data !== ex[i]) begin fails++; $display("FAIL load%0d_data: got %h want %h", i, r_data, ex[i]); end
            tests++; if (r_lat != 3) begin fails++; $display("FAIL load%0d_latency: got %0d want 3", i, r_lat); end
            tests++; if (r_err !== 1'b0) begin fails++; $display("FAIL load%0d_error: got %b want 0", i, r_err); end
            tests++; if (r_en != 1) begin fails++; $display("FAIL load%0d_en_cycles: got %0d want 1", i, r_en); end
        end
    endtask

    task automatic test_stores();
        do_req(1'b1, SIZE_B, 1'b0, 32'h1, 32'h123456AA);
        tests++; if (r_lat != 4) begin fails++; $display("FAIL sb_latency: got %0d want 4", r_lat); end
        tests++; if (r_we != 1) begin fails++; $display("FAIL sb_we_cycles: got %0d want 1", r_we); end
        tests++; if (r_err !== 1'b0 || r_data !== 32'h0) begin fails++; $display("FAIL sb_resp: got err %b data %h want 0/0", r_err, r_data); end
        tests++; if (mem[0] !== 32'h8765AA21) begin fails++; $display("FAIL sb_mem: got %h want 8765aa21", mem[0]); end
        do_req(1'b0, SIZE_W, 1'b0, 32'h0, 32'h0);
        tests++; if (r_data !== 32'h8765AA21) begin fails++; $display("FAIL sb_readback: got %h want 8765aa21", r_data); end
        do_req(1'b1, SIZE_W, 1'b0, 32'h4, 32'hDEADBEEF);
        tests++; if (r_lat != 2) begin fails++; $display("FAIL sw_latency: got %0d want 2", r_lat); end
        tests++; if (r_we != 1 || r_en != 1) begin fails++; $display("FAIL sw_enables: got en %0d we %0d want 1/1", r_en, r_we); end
        do_req(1'b0, SIZE_W, 1'b0, 32'h4, 32'h0);
        tests++; if (r_data !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_readback: got %h want deadbeef", r_data); end
    endtask

    task automatic test_errors();
        logic        wr [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [1:0]  sz [4] = '{SIZE_H, SIZE_W, SIZE_X, SIZE_W};
        logic [31:0] ad [4] = '{32'h1, 32'h2, 32'h0, 32'h800};
        for (int i = 0; i < 4; i++) begin
            do_req(wr[i], sz[i], 1'b0, ad[i], 32'hFFFFFFFF);
            tests++; if (r_lat != 1) begin fails++; $display("FAIL err%0d_latency: got %0d want 1", i, r_lat); end
            tests++; if (r_err !== 1'b1) begin fails++; $display("FAIL err%0d_flag: got %b want 1", i, r_err); end
            tests++; if (r_data !== 32'h0) begin fails++; $display("FAIL err%0d_data: got %h want 0", i, r_data); end
            tests++; if (r_en != 0) begin fails++; $display("FAIL err%0d_en_cycles: got %0d want 0", i, r_en); end
        end
    endtask

    task automatic test_reset_abort();
        logic seen_we = 1'b0, seen_resp = 1'b0;
        preload(9'd0, 32'h87654321);
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_size = SIZE_B; req_addr = 32'h0; req_wdata = 32'hFF;
        @(posedge clock); #1 req_valid = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        tests++; if (ram_enable !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL abort_async: got en %b ready %b want 0/1", ram_enable, req_ready); end
        repeat (3) begin
            @(negedge clock);
            if (ram_write_enable) seen_we = 1'b1;
            if (resp_valid) seen_resp = 1'b1;
        end
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (ram_write_enable) seen_we = 1'b1;
            if (resp_valid) seen_resp = 1'b1;
        end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL abort_ready: got %b want 1", req_ready); end
        tests++; if (seen_we || seen_resp) begin fails++; $display("FAIL abort_activity: got we %b resp %b want 0/0", seen_we, seen_resp); end
        tests++; if (mem[0] !== 32'h87654321) begin fails++; $display("FAIL abort_mem: got %h want 87654321", mem[0]); end
        do_req(1'b0, SIZE_W, 1'b0, 32'h0, 32'h0);
        tests++; if (r_data !== 32'h87654321) begin fails++; $display("FAIL abort_readback: got %h want 87654321", r_data); end
    endtask

    task automatic test_back_to_back();
        int  n_resp = 0;
        logic seen_we = 1'b0;
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_size = SIZE_W; req_unsigned = 1'b0; req_addr = 32'h4; req_wdata = '0;
        for (int w = 1; w <= 8; w++) begin
            @(negedge clock);
            if (resp_valid) n_resp++;
            if (ram_write_enable) seen_we = 1'b1;
            if (w == 3) begin
                tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL b2b_first: got v %b data %h want 1/deadbeef", resp_valid, resp_rdata); end
                tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL b2b_busy_ready: got %b want 0", req_ready); end
            end
            if (w == 4) begin
                tests++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin fails++; $display("FAIL b2b_idle: got ready %b v %b want 1/0", req_ready, resp_valid); end
            end
            if (w == 7) begin
                tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h87654321) begin fails++; $display("FAIL b2b_second: got v %b data %h want 1/87654321", resp_valid, resp_rdata); end
            end
            if (w < 4) begin
                req_write = 1'b1; req_size = SIZE_W; req_addr = 32'h0; req_wdata = w;
            end else if (w == 4) begin
                req_write = 1'b0; req_size = SIZE_W; req_addr = 32'h0;
            end else req_valid = 1'b0;
        end
        tests++; if (n_resp != 2 || seen_we) begin fails++; $display("FAIL b2b_count: got resp %0d we %b want 2/0", n_resp, seen_we); end
        tests++; if (mem[0] !== 32'h87654321) begin fails++; $display("FAIL b2b_mem: got %h want 87654321", mem[0]); end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Load/store sequencer between the RV32I core's memory stage and the word-wide synchronous data RAM (1-cycle registered read, write-first port, `ram_enable`/`write_enable` controls). It accepts byte, halfword and word requests over a valid/ready handshake. It drives the RAM port, performing a single read or write for aligned word accesses and a read-modify-write for sub-word stores. It returns lane-aligned, sign- or zero-extended load data and flags misaligned or out-of-range accesses.

## Interface
- `RAM_WIDTH`, 32, RAM word width; fixed at 32.
- `RAM_ADDR_BITS`, 9, RAM word-address width; capacity is 2^RAM_ADDR_BITS words.
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  zero-extend loads (LBU/LHU).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_error`  out  1  misaligned, illegal size or out of range; valid with `resp_valid`.
- `ram_enable`  out  1  to RAM `ram_enable`.
- `ram_write_enable`  out  1  to RAM `write_enable`.
- `ram_address`  out  RAM_ADDR_BITS  word address = `req_addr[RAM_ADDR_BITS+1:2]`.
- `ram_input_data`  out  32  write word.
- `ram_output_data`  in  32  RAM read data, valid the cycle after an enabled read edge.

## Operation
- Accept on a rising edge with `req_valid && req_ready`. All request fields are latched and the inputs are then ignored until the next IDLE.
- Error check at accept:
  - `req_size==11` is an error.
  - Half with `addr[0]` set is an error.
  - Word with `addr[1:0]!=0` is an error.
  - `addr[31:RAM_ADDR_BITS+2]!=0` is an error.
  - On error: go directly to RESP with `resp_error=1`. No RAM enable is ever driven.
- FSM states: IDLE, RD, CAPT, MERGE, WR, RESP.
  - Load: IDLE→RD→CAPT→RESP.
  - Word store: IDLE→WR→RESP.
  - Byte/half store: IDLE→RD→MERGE→WR→RESP.
  - Error: IDLE→RESP.
  - RESP→IDLE always.
- RAM drive:
  - RD: `ram_enable=1`, `ram_write_enable=0`.
  - WR: `ram_enable=1`, `ram_write_enable=1`, `ram_input_data` = registered word.
  - Otherwise both enables are 0.
  - `ram_address` is held constant from RD/WR through RESP.
- Little-endian lanes:
  - Byte lane = `addr[1:0]`; half lane = `addr[1]`.
  - CAPT shifts the selected lane to bit 0, extends by `req_unsigned`, and registers the result into `resp_rdata`.
  - MERGE replaces only the addressed lane with `req_wdata[7:0]` or `[15:0]` and registers the full word; the other lanes keep their read values.
- `resp_valid` is high exactly one cycle, in RESP. There is no response backpressure.

## Timing
- Reset values: `req_ready=1` (state IDLE); `resp_valid=0`, `resp_error=0`, `resp_rdata=0`; `ram_enable=0`, `ram_write_enable=0`, `ram_address=0`, `ram_input_data=0`.
- Latency from accept edge to `resp_valid` high: load 3 cycles, word store 2, sub-word store 4, error 1.
- Throughput: next accept no earlier than the edge after RESP, i.e. one idle-ready cycle between requests.
- Reset mid-operation:
  - The FSM returns to IDLE immediately.
  - Enables drop asynchronously, so a WR not yet clocked is not performed.
  - An RMW interrupted before WR leaves memory unchanged.
  - No `resp_valid` is produced for the aborted request.
- All outputs are registered or decoded from the state register only; there are no combinational paths from `req_*` to outputs.

## Structure
- Package `data_mem_ctrl_pkg`: size encodings (`SIZE_B`, `SIZE_H`, `SIZE_W`), FSM state enum, lane-select helper constants.
- One combinational sub-module, `mem_lane_align`: extract/extend for loads and lane merge for stores, parameterised on `RAM_WIDTH`.
- The FSM, request latch and RAM drive live in the top module.

## Test plan
- RAM word 0 = 0x87654321; LW addr 0x0 → `resp_rdata`=0x87654321, `resp_valid` at accept+3, `resp_error`=0, exactly one `ram_enable` cycle.
- Same word:
  - LB addr 0x3 → 0xFFFFFF87.
  - LBU addr 0x3 → 0x00000087.
  - LH addr 0x2 → 0xFFFF8765.
  - LHU addr 0x0 → 0x00004321.
- SB addr 0x1 wdata 0x123456AA → word 0 becomes 0x8765AA21; `resp_valid` at accept+4; `ram_write_enable` high exactly one cycle; then SW addr 0x4 0xDEADBEEF → `resp_valid` at accept+2, readback matches.
- Error cases, each with `resp_error=1`, `resp_rdata`=0, `resp_valid` at accept+1 and `ram_enable` never asserted:
  - SH addr 0x1.
  - LW addr 0x2.
  - `req_size`=11.
  - LW addr 0x800.
- Assert `reset_n`=0 during MERGE of SB addr 0x0 0xFF → no RAM write, no response; `req_ready`=1 after release; LW addr 0x0 returns the original 0x87654321.
- Hold `req_valid` high with changing fields across an in-flight load → only the first request is serviced until IDLE; the next accept occurs the cycle after RESP.
